uart_crc_receiver: RTL

UART_CRC_RECEIVER -- requirements
Module: uart_crc_receiver

---
 rtl/uart_crc_pkg.sv | 22 ++
 rtl/crc16_byte.sv | 21 ++
 rtl/uart_crc_receiver.sv | 124 ++++++++++++
 3 files changed

// File: rtl/uart_crc_pkg.sv
// Shared constants and FSM encoding for the CRC-protected UART receiver.
// The transmitter side uses the same frame layout and CRC setup.
package uart_crc_pkg;
  localparam logic [15:0] CRC_POLY     = 16'h1021;
  localparam logic [15:0] CRC_INIT     = 16'hFFFF;
  localparam int          FRAME_BITS   = 26;
  localparam int          PAYLOAD_BITS = 24;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    SHIFT = 3'd2,
    STOP  = 3'd3,
    CHECK = 3'd4
  } rx_state_t;

  typedef struct packed {
    logic [7:0]  data;
    logic [15:0] crc;
    logic        crc_error;
  } rx_result_t;
endpackage

// File: rtl/crc16_byte.sv
// One-byte CRC-16-CCITT step: MSB-first, no reflection, no final XOR.
module crc16_byte
  import uart_crc_pkg::*;
(
  input  logic [7:0]  data,
  input  logic [15:0] seed,
  output logic [15:0] crc
);
  logic [15:0] c;
  logic        fb;

  always_comb begin
    c  = seed;
    fb = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    end
    crc = c;
  end
endmodule

// File: rtl/uart_crc_receiver.sv
// UART receiver for a 26-bit frame: start, data byte, 16-bit CRC, stop.
// The CRC is checked against the data byte once the stop bit is confirmed.
module uart_crc_receiver
  import uart_crc_pkg::*;
#(
  parameter int BAUD_RATE = 9600,
  parameter int CLK_FREQ  = 50000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx_in,
  output logic [7:0]  data_out,
  output logic [15:0] crc_out,
  output logic        data_valid,
  output logic        crc_error,
  output logic        frame_error,
  output logic        rx_busy
);
  localparam int BIT_TICKS  = CLK_FREQ / BAUD_RATE;
  localparam int HALF_TICKS = BIT_TICKS / 2;
  localparam int CW         = $clog2(BIT_TICKS) + 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_TICKS - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_TICKS - 1);
  localparam logic [4:0]    LAST_BIT  = 5'(PAYLOAD_BITS - 1);

  rx_state_t               state, nxt;
  logic [1:0]              sync;
  logic                    rx_s, rx_prev, fall;
  logic [CW-1:0]           cnt;
  logic [4:0]              bit_cnt;
  logic [PAYLOAD_BITS-1:0] shift;
  logic [15:0]             crc_calc;
  logic                    half_hit, bit_hit, stop_ok, stop_bad;
  rx_result_t              res;

  assign rx_s     = sync[1];
  assign fall     = rx_prev & ~rx_s;
  assign half_hit = (cnt == HALF_LAST);
  assign bit_hit  = (cnt == BIT_LAST);
  assign stop_ok  = (state == STOP) && bit_hit && rx_s;
  assign stop_bad = (state == STOP) && bit_hit && !rx_s;

  crc16_byte u_crc (
    .data (shift[7:0]),
    .seed (CRC_INIT),
    .crc  (crc_calc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync    <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      sync    <= {sync[0], rx_in};
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (fall) nxt = START;
      START: if (half_hit) nxt = rx_s ? IDLE : SHIFT;
      SHIFT: if (bit_hit && bit_cnt == LAST_BIT) nxt = STOP;
      STOP:  if (bit_hit) nxt = rx_s ? CHECK : IDLE;
      CHECK: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      case (state)
        START: begin
          cnt     <= half_hit ? '0 : cnt + 1'b1;
          bit_cnt <= '0;
        end
        SHIFT: begin
          cnt <= bit_hit ? '0 : cnt + 1'b1;
          if (bit_hit) begin
            bit_cnt <= bit_cnt + 1'b1;
            shift   <= {rx_s, shift[PAYLOAD_BITS-1:1]};
          end
        end
        STOP:    cnt <= bit_hit ? '0 : cnt + 1'b1;
        default: cnt <= '0;
      endcase
    end
  end

  // Results are captured on the stop-bit sample so they are already stable
  // during the CHECK cycle, when data_valid is raised.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res         <= '0;
      frame_error <= 1'b0;
    end else begin
      frame_error <= stop_bad;
      if (stop_ok) begin
        res.data      <= shift[7:0];
        res.crc       <= shift[23:8];
        res.crc_error <= (crc_calc != shift[23:8]);
      end
    end
  end

  always_comb begin
    data_valid = (state == CHECK);
    rx_busy    = (state != IDLE);
  end

  assign data_out  = res.data;
  assign crc_out   = res.crc;
  assign crc_error = res.crc_error;
endmodule
